// File: rtl/hyper_ck_burst_gen.sv
// HyperBus CK/CK# burst generator: register-divided, glitch-free differential clock
// steered to one of NB_CH channels, with rise/fall strobes for the DDR datapath.
module hyper_ck_burst_gen #(
   parameter int NB_CH = 2,
   parameter int CNT_W = 16,
   parameter int DIV_W = 4,
   parameter int CH_W  = (NB_CH > 1) ? $clog2(NB_CH) : 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [DIV_W-1:0] cfg_div_i,
   input  logic             start_valid_i,
   output logic             start_ready_o,
   input  logic [CNT_W-1:0] burst_len_i,
   input  logic [CH_W-1:0]  ch_i,
   input  logic             abort_i,
   output logic [NB_CH-1:0] ck_o,
   output logic [NB_CH-1:0] ck_no,
   output logic             rise_o,
   output logic             fall_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [CNT_W-1:0] cycles_o
);

   typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

   state_t           r_state, w_state_next;
   logic [DIV_W-1:0] r_div, r_phase, w_phase_next;
   logic [CNT_W-1:0] r_len, r_cycles, w_cycles_next, w_cycles_inc;
   logic [CH_W-1:0]  r_ch, w_ch_eff;
   logic             r_abort, w_abort_next;
   logic             r_rise, r_fall, r_done;
   logic             w_rise_next, w_fall_next, w_done_next;
   logic [NB_CH-1:0] r_ck, w_ck_next;
   logic             w_accept, w_phase_end;

   assign w_accept     = (r_state == S_IDLE) && start_valid_i;
   assign w_phase_end  = (r_phase == r_div);
   assign w_cycles_inc = r_cycles + CNT_W'(1);
   assign w_ch_eff     = w_accept ? ch_i : r_ch;

   always_comb begin
      w_state_next  = r_state;
      w_phase_next  = r_phase;
      w_cycles_next = r_cycles;
      w_abort_next  = r_abort;
      w_done_next   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_cycles_next = '0;
               w_phase_next  = '0;
               if (burst_len_i == '0) begin
                  w_done_next = 1'b1;
               end else begin
                  w_state_next = S_HIGH;
               end
            end
         end
         S_HIGH: begin
            w_abort_next = r_abort | abort_i;
            if (w_phase_end) begin
               w_phase_next = '0;
               w_state_next = S_LOW;
            end else begin
               w_phase_next = r_phase + DIV_W'(1);
            end
         end
         S_LOW: begin
            w_abort_next = r_abort | abort_i;
            if (w_phase_end) begin
               w_phase_next  = '0;
               w_cycles_next = w_cycles_inc;
               // Abort only ever takes effect here, so the last pulse is always full width.
               if ((w_cycles_inc == r_len) || r_abort || abort_i) begin
                  w_state_next = S_IDLE;
                  w_done_next  = 1'b1;
                  w_abort_next = 1'b0;
               end else begin
                  w_state_next = S_HIGH;
               end
            end else begin
               w_phase_next = r_phase + DIV_W'(1);
            end
         end
         default: begin
            w_state_next = S_IDLE;
            w_abort_next = 1'b0;
         end
      endcase
      w_rise_next = (w_state_next == S_HIGH) && (r_state != S_HIGH);
      w_fall_next = (w_state_next == S_LOW) && (r_state == S_HIGH);
   end

   // Out-of-range channel selects match no lane, so every CK stays low.
   genvar gi;
   generate
      for (gi = 0; gi < NB_CH; gi++) begin : g_lane
         assign w_ck_next[gi] = (w_state_next == S_HIGH) && (w_ch_eff == CH_W'(gi));
      end
   endgenerate

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state  <= S_IDLE;
         r_phase  <= '0;
         r_cycles <= '0;
         r_abort  <= 1'b0;
         r_div    <= '0;
         r_len    <= '0;
         r_ch     <= '0;
         r_ck     <= '0;
         r_rise   <= 1'b0;
         r_fall   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_phase  <= w_phase_next;
         r_cycles <= w_cycles_next;
         r_abort  <= w_abort_next;
         r_ck     <= w_ck_next;
         r_rise   <= w_rise_next;
         r_fall   <= w_fall_next;
         r_done   <= w_done_next;
         if (w_accept) begin
            r_div <= cfg_div_i;
            r_len <= burst_len_i;
            r_ch  <= ch_i;
         end
      end
   end

   assign ck_o          = r_ck;
   assign ck_no         = ~r_ck;
   assign rise_o        = r_rise;
   assign fall_o        = r_fall;
   assign done_o        = r_done;
   assign cycles_o      = r_cycles;
   assign busy_o        = (r_state != S_IDLE);
   assign start_ready_o = (r_state == S_IDLE);

endmodule

// File: tb/tb_hyper_ck_burst_gen.sv
// Directed bench for hyper_ck_burst_gen: table of bursts checked cycle by cycle
// against a period/duty model, plus back-to-back and mid-burst reset sequences.
module tb_hyper_ck_burst_gen;

   localparam int NB_CH  = 3;
   localparam int CNT_W  = 16;
   localparam int DIV_W  = 4;
   localparam int CH_W   = 2;
   localparam int BUDGET = 200;

   logic             clk_i = 1'b0;
   logic             rst_ni;
   logic [DIV_W-1:0] cfg_div_i;
   logic             start_valid_i;
   logic             start_ready_o;
   logic [CNT_W-1:0] burst_len_i;
   logic [CH_W-1:0]  ch_i;
   logic             abort_i;
   logic [NB_CH-1:0] ck_o;
   logic [NB_CH-1:0] ck_no;
   logic             rise_o, fall_o, busy_o, done_o;
   logic [CNT_W-1:0] cycles_o;

   int errors = 0;
   int checks = 0;

   always #5 clk_i = ~clk_i;

   hyper_ck_burst_gen #(.NB_CH(NB_CH), .CNT_W(CNT_W), .DIV_W(DIV_W), .CH_W(CH_W)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .cfg_div_i(cfg_div_i),
      .start_valid_i(start_valid_i), .start_ready_o(start_ready_o),
      .burst_len_i(burst_len_i), .ch_i(ch_i), .abort_i(abort_i),
      .ck_o(ck_o), .ck_no(ck_no), .rise_o(rise_o), .fall_o(fall_o),
      .busy_o(busy_o), .done_o(done_o), .cycles_o(cycles_o)
   );

   typedef struct {
      int div;
      int len;
      int ch;
      int abort_k;   // cycle after accept in which abort_i is pulsed, 0 = none
      int exp_done;  // cycle after accept in which done_o is expected
      int exp_cyc;   // completed CK cycles expected
   } vec_t;

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   // Starts from a negedge; returns at the negedge of the done cycle.
   task automatic run_burst(input int div, input int len, input int ch,
                            input int abort_k, input int exp_done, input int exp_cyc);
      int k, done_k, rises, falls, wave_err, first_bad, half;
      logic exp_ck, prev_ck;
      logic [NB_CH-1:0] exp_vec;
      cfg_div_i     = DIV_W'(div);
      burst_len_i   = CNT_W'(len);
      ch_i          = CH_W'(ch);
      start_valid_i = 1'b1;
      @(posedge clk_i);
      #1;
      start_valid_i = 1'b0;
      cfg_div_i     = ~cfg_div_i;
      burst_len_i   = burst_len_i + CNT_W'(3);
      ch_i          = ch_i ^ CH_W'(1);
      half = div + 1;
      prev_ck = 1'b0;
      done_k = 0; rises = 0; falls = 0; wave_err = 0; first_bad = 0;
      for (k = 1; k <= BUDGET && done_k == 0; k++) begin
         abort_i = (k == abort_k);
         @(negedge clk_i);
         exp_ck  = (k <= 2 * exp_cyc * half) && (((k - 1) % (2 * half)) < half);
         exp_vec = '0;
         if (ch < NB_CH) exp_vec[ch] = exp_ck;
         if (ck_o !== exp_vec || ck_no !== ~exp_vec ||
             rise_o !== (exp_ck & ~prev_ck) || fall_o !== (~exp_ck & prev_ck) ||
             busy_o !== (k < exp_done) || start_ready_o !== (k >= exp_done) ||
             done_o !== (k == exp_done)) begin
            if (wave_err == 0) first_bad = k;
            wave_err++;
         end
         if (rise_o === 1'b1) rises++;
         if (fall_o === 1'b1) falls++;
         if (done_o === 1'b1) done_k = k;
         prev_ck = exp_ck;
         if (done_k == 0) begin
            @(posedge clk_i);
            #1;
         end
      end
      abort_i = 1'b0;
      check("done_cycle", done_k, exp_done);
      check("cycles_o", int'(cycles_o), exp_cyc);
      check("rise_count", rises, exp_cyc);
      check("fall_count", falls, exp_cyc);
      check($sformatf("waveform_first_bad_cycle_%0d", first_bad), wave_err, 0);
      $display("burst div=%0d len=%0d ch=%0d abort_k=%0d -> done at T+%0d cycles=%0d rises=%0d falls=%0d",
               div, len, ch, abort_k, done_k, cycles_o, rises, falls);
   endtask

   vec_t vecs[7];

   initial begin
      int bad;
      vecs[0] = '{div: 0,  len: 4,  ch: 1, abort_k: 0, exp_done: 9,  exp_cyc: 4};
      vecs[1] = '{div: 2,  len: 3,  ch: 0, abort_k: 0, exp_done: 19, exp_cyc: 3};
      vecs[2] = '{div: 1,  len: 10, ch: 1, abort_k: 5, exp_done: 9,  exp_cyc: 2};
      vecs[3] = '{div: 3,  len: 0,  ch: 0, abort_k: 1, exp_done: 1,  exp_cyc: 0};
      vecs[4] = '{div: 0,  len: 2,  ch: 3, abort_k: 0, exp_done: 5,  exp_cyc: 2};
      vecs[5] = '{div: 15, len: 1,  ch: 2, abort_k: 0, exp_done: 33, exp_cyc: 1};
      vecs[6] = '{div: 0,  len: 5,  ch: 0, abort_k: 1, exp_done: 3,  exp_cyc: 1};

      rst_ni = 1'b0; cfg_div_i = '0; start_valid_i = 1'b0;
      burst_len_i = '0; ch_i = '0; abort_i = 1'b0;
      repeat (3) @(negedge clk_i);
      check("reset_ck_o", int'(ck_o), 0);
      check("reset_ck_no", int'(ck_no), 7);
      rst_ni = 1'b1;

      // Idle with start_valid low: nothing may move for 100 cycles.
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk_i);
         if (ck_o !== '0 || ck_no !== '1 || start_ready_o !== 1'b1 || busy_o !== 1'b0 ||
             rise_o !== 1'b0 || fall_o !== 1'b0 || done_o !== 1'b0 || cycles_o !== '0)
            bad++;
      end
      check("idle_100_cycles", bad, 0);

      for (int v = 0; v < 7; v++)
         run_burst(vecs[v].div, vecs[v].len, vecs[v].ch, vecs[v].abort_k,
                   vecs[v].exp_done, vecs[v].exp_cyc);

      // cycles_o holds after done until the next accept.
      repeat (4) @(negedge clk_i);
      check("cycles_hold", int'(cycles_o), 1);

      // Back-to-back: second burst accepted in the done cycle of the first.
      run_burst(2, 3, 0, 0, 19, 3);
      run_burst(0, 1, 1, 0, 3, 1);

      // Reset in the middle of a high phase.
      cfg_div_i = DIV_W'(3); burst_len_i = CNT_W'(5); ch_i = CH_W'(1);
      start_valid_i = 1'b1;
      @(posedge clk_i);
      #1;
      start_valid_i = 1'b0;
      @(negedge clk_i);
      @(negedge clk_i);
      check("pre_reset_ck_high", int'(ck_o), 2);
      #2;
      rst_ni = 1'b0;
      #1;
      check("async_reset_ck_o", int'(ck_o), 0);
      check("async_reset_ck_no", int'(ck_no), 7);
      check("async_reset_busy", int'(busy_o), 0);
      check("async_reset_ready", int'(start_ready_o), 1);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      check("post_reset_ready", int'(start_ready_o), 1);
      check("post_reset_ck_o", int'(ck_o), 0);
      check("post_reset_cycles", int'(cycles_o), 0);
      run_burst(0, 2, 0, 0, 5, 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/hyper_ck_burst_gen.md
# hyper_ck_burst_gen

Parametrised HyperBus clock generator: produces a glitch-free, programmable-rate differential clock pair (CK/CK#) on one of NB_CH channel outputs, for a requested number of clock cycles. The clock is derived from the system clock by a register-based divider, not a latch gate. Phase strobes let the DDR datapath launch data aligned to the generated edges. It sits between the transaction FSM and the PHY pads, replacing the single-channel gate/inverter pair.

## Interface
- NB_CH, 2, number of CK/CK# output pairs (≥1)
- CNT_W, 16, width of burst length and cycle counter
- DIV_W, 4, width of half-period divider setting
- CH_W, (NB_CH>1 ? $clog2(NB_CH) : 1), width of channel select
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- cfg_div_i  in  DIV_W  half-period = cfg_div_i+1 clk_i cycles; sampled at accept
- start_valid_i  in  1  burst request
- start_ready_o  out  1  block can accept a burst
- burst_len_i  in  CNT_W  number of CK cycles; sampled at accept
- ch_i  in  CH_W  target channel; sampled at accept
- abort_i  in  1  request early stop; sampled only while busy
- ck_o  out  NB_CH  CK per channel (registered)
- ck_no  out  NB_CH  CK# per channel, = ~ck_o
- rise_o  out  1  strobe: first cycle ck is high
- fall_o  out  1  strobe: first cycle ck is low after a high phase
- busy_o  out  1  burst in progress
- done_o  out  1  one-cycle pulse at burst end
- cycles_o  out  CNT_W  completed CK cycles of current/last burst

## Operation
- FSM states IDLE, HIGH, LOW. Phase counter (DIV_W) and cycle counter (CNT_W).
- IDLE: start_ready_o=1, busy_o=0. On start_valid_i&start_ready_o: latch div, len, ch; clear cycles_o.
  - len==0: stay IDLE, done_o=1 next cycle, no clock edge.
  - len>0: go HIGH.
- HIGH: internal ck=1 for div+1 cycles, then LOW.
- LOW: ck=0 for div+1 cycles; at end, cycles_o increments. If cycles_o+1==len or abort pending: go IDLE with done_o=1; else go HIGH.
- Abort: abort_i held as pending flag once seen in HIGH/LOW; current high phase and following low phase always complete (no runt pulse). abort_i in IDLE or in the accept cycle ignored. Pending flag cleared at return to IDLE.
- Channel: ck_o[ch]=internal ck; all other bits 0. ch≥NB_CH: burst runs (strobes, counters, done) but all ck_o stay 0.
- ck_no = ~ck_o bitwise always, idle value all ones.
- cfg_div_i, burst_len_i, ch_i changes during a burst have no effect.
- cycles_o holds final value after done until next accept; aborted burst reports fewer than len.

## Timing
- Reset (async, immediate): state IDLE, ck_o=0, ck_no=all 1, start_ready_o=1, busy_o=0, rise_o=fall_o=done_o=0, cycles_o=0, abort pending cleared. Reset mid-burst truncates high phase immediately (accepted).
- Accept at edge T: ck_o rises in cycle T+1 with rise_o=1, busy_o=1, start_ready_o=0.
- Period 2*(div+1) clk_i cycles, 50 % duty; div=0 gives clk_i/2.
- Burst of L cycles: ck high cycles T+1..T+1+div for first cycle; last low phase ends cycle T+2L(div+1); done_o=1, busy_o=0, start_ready_o=1 in cycle T+2L(div+1)+1.
- Back-to-back: accept in the done cycle; next rise one cycle later, so gap between bursts is one extra low cycle.
- fall_o asserted on every high→low transition including the last.
- rise_o/fall_o/done_o exactly one cycle each.

## Test plan
- Reset then idle: ck_o=0, ck_no=all 1, start_ready_o=1 -> no toggles over 100 cycles.
- NB_CH=2, div=0, len=4, ch=1: ck_o[1] toggles every cycle, 4 rise_o and 4 fall_o pulses, done_o in cycle T+9, cycles_o=4, ck_o[0]=0 throughout.
- div=2, len=3: high/low phases 3 cycles each, done_o at T+19; back-to-back second burst accepted in done cycle, rises at T+20.
- abort_i pulsed 1 cycle during the 2nd high phase of len=10, div=1: high phase completes, low completes, done_o, cycles_o=2, no runt pulse.
- len=0 accept: done_o one cycle later, ck_o never rises, cycles_o=0; ch=3 with NB_CH=2, len=2: done_o at T+5, ck_o stays 0.
- rst_ni asserted mid-high phase: ck_o=0 and ck_no=1 immediately, state IDLE, start_ready_o=1 after release.
